// File: rtl/hp_manager.sv
// Hit-point bookkeeping for the two-player factorization game: applies damage on
// GOOD/OUCH entry, reports kills to the controller, and drives the HP LEDs and flashes.
module hp_manager #(
    parameter int HP_MAX    = 5,
    parameter int HP_W      = 3,
    parameter int DMG       = 1,
    parameter int FLASH_CYC = 25_000_000,
    parameter int CNT_W     = 25
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [3:0]      STATE,
    input  logic            NEW_GAME,
    output logic [1:0]      HP_OUT,
    output logic [HP_W-1:0] MY_HP,
    output logic [HP_W-1:0] OPP_HP,
    output logic [9:0]      HP_BAR,
    output logic            FLASH_SELF,
    output logic            FLASH_OPP
);

    localparam logic [3:0] ST_READY = 4'h2;
    localparam logic [3:0] ST_GOOD  = 4'h8;
    localparam logic [3:0] ST_OUCH  = 4'h9;
    localparam logic [3:0] ST_WIN   = 4'hA;
    localparam logic [3:0] ST_LOSE  = 4'hB;

    localparam logic [HP_W-1:0]  HP_MAX_V = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0]  DMG_V    = HP_W'(DMG);
    localparam logic [CNT_W-1:0] FLASH_V  = CNT_W'(FLASH_CYC);

    function automatic logic [4:0] therm(input logic [HP_W-1:0] hp);
        logic [4:0] t;
        t = '0;
        for (int i = 0; i < 5; i++) begin
            t[i] = (i < HP_MAX) && (i < int'(hp));
        end
        return t;
    endfunction

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp);
        return (hp > DMG_V) ? hp - DMG_V : '0;
    endfunction

    logic [3:0]       prev_q;
    logic [HP_W-1:0]  my_hp_q, my_hp_d;
    logic [HP_W-1:0]  opp_hp_q, opp_hp_d;
    logic [CNT_W-1:0] self_cnt_q, self_cnt_d;
    logic [CNT_W-1:0] opp_cnt_q, opp_cnt_d;
    logic [1:0]       hp_out_q, hp_out_d;
    logic [9:0]       hp_bar_q, hp_bar_d;

    logic hit_opp, hit_self, game_end, reload;

    assign hit_opp  = (STATE == ST_GOOD) && (prev_q != ST_GOOD);
    assign hit_self = (STATE == ST_OUCH) && (prev_q != ST_OUCH);
    assign game_end = (STATE == ST_READY) && ((prev_q == ST_WIN) || (prev_q == ST_LOSE));
    assign reload   = NEW_GAME || game_end;

    always_comb begin
        my_hp_d    = my_hp_q;
        opp_hp_d   = opp_hp_q;
        self_cnt_d = (self_cnt_q != '0) ? self_cnt_q - 1'b1 : '0;
        opp_cnt_d  = (opp_cnt_q != '0) ? opp_cnt_q - 1'b1 : '0;
        // A reload outranks any hit seen in the same cycle, including its flash.
        if (reload) begin
            my_hp_d    = HP_MAX_V;
            opp_hp_d   = HP_MAX_V;
            self_cnt_d = '0;
            opp_cnt_d  = '0;
        end else begin
            if (hit_opp) begin
                opp_hp_d  = sat_sub(opp_hp_q);
                opp_cnt_d = FLASH_V;
            end
            if (hit_self) begin
                my_hp_d    = sat_sub(my_hp_q);
                self_cnt_d = FLASH_V;
            end
        end
    end

    // Status and LED bar follow the HP registers by one cycle.
    always_comb begin
        hp_out_d = 2'b00;
        if (opp_hp_q == '0) begin
            hp_out_d = 2'b10;
        end else if (my_hp_q == '0) begin
            hp_out_d = 2'b01;
        end
        hp_bar_d = {therm(opp_hp_q), therm(my_hp_q)};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_q     <= ST_READY;
            my_hp_q    <= HP_MAX_V;
            opp_hp_q   <= HP_MAX_V;
            self_cnt_q <= '0;
            opp_cnt_q  <= '0;
            hp_out_q   <= 2'b00;
            hp_bar_q   <= {therm(HP_MAX_V), therm(HP_MAX_V)};
        end else begin
            prev_q     <= STATE;
            my_hp_q    <= my_hp_d;
            opp_hp_q   <= opp_hp_d;
            self_cnt_q <= self_cnt_d;
            opp_cnt_q  <= opp_cnt_d;
            hp_out_q   <= hp_out_d;
            hp_bar_q   <= hp_bar_d;
        end
    end

    assign HP_OUT     = hp_out_q;
    assign MY_HP      = my_hp_q;
    assign OPP_HP     = opp_hp_q;
    assign HP_BAR     = hp_bar_q;
    assign FLASH_SELF = (self_cnt_q != '0);
    assign FLASH_OPP  = (opp_cnt_q != '0);

endmodule
